// File: rtl/alu_mc.sv
// Multi-cycle integer execution unit: single-cycle logic/arith/shift/compare plus
// iterative shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             branch_alu
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_XOR   = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SRL   = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_SLT   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_MUL   = 5'b01010;
    localparam logic [4:0] OP_MULH  = 5'b01011;
    localparam logic [4:0] OP_MULHU = 5'b01100;
    localparam logic [4:0] OP_DIV   = 5'b01101;
    localparam logic [4:0] OP_DIVU  = 5'b01110;
    localparam logic [4:0] OP_REM   = 5'b01111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

    state_t             r_state, w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_branch;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_acc, r_q, r_b, r_a_orig;
    logic               r_neg, r_div0;

    logic               w_out_free, w_accept, w_is_mc, w_load_sc, w_load_fix;
    logic               w_signed_in, w_div_op;
    logic [SH_W-1:0]    w_shamt;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_sc_result, w_fix_result, w_mulh_neg;
    logic [WIDTH-1:0]   w_acc_next, w_q_next;
    logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;

    assign w_is_mc     = (alu_control[4:3] == 2'b01) && (alu_control[2:1] != 2'b00);
    assign w_shamt     = src_b[SH_W-1:0];
    assign w_signed_in = (alu_control == OP_MULH) || (alu_control == OP_DIV) || (alu_control == OP_REM);
    assign w_a_abs     = (w_signed_in && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_b_abs     = (w_signed_in && src_b[WIDTH-1]) ? -src_b : src_b;
    assign w_div_op    = (r_op == OP_DIV) || (r_op == OP_DIVU) || (r_op == OP_REM);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn)       r_state <= S_IDLE;
        else if (flush)  r_state <= S_IDLE;
        else             r_state <= w_next_state;
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mc)   w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == CNT_W'(1))    w_next_state = S_FIX;
            S_FIX:   if (w_out_free)            w_next_state = S_IDLE;
            default:                            w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs and handshake qualifiers
    always_comb begin
        w_out_free = !r_out_valid || out_ready;
        in_ready   = (r_state == S_IDLE) && w_out_free;
        w_accept   = in_valid && in_ready && !flush;
        w_load_sc  = w_accept && !w_is_mc;
        w_load_fix = (r_state == S_FIX) && w_out_free && !flush;
    end

    always_comb begin
        case (alu_control)
            OP_AND:  w_sc_result = src_a & src_b;
            OP_OR:   w_sc_result = src_a | src_b;
            OP_ADD:  w_sc_result = src_a + src_b;
            OP_SUB:  w_sc_result = src_a - src_b;
            OP_XOR:  w_sc_result = src_a ^ src_b;
            OP_SLL:  w_sc_result = src_a << w_shamt;
            OP_SRL:  w_sc_result = src_a >> w_shamt;
            OP_SRA:  w_sc_result = $signed(src_a) >>> w_shamt;
            OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, src_a < src_b};
            default: w_sc_result = '0;
        endcase
    end

    // One iteration: multiply shifts the product right, divide shifts the remainder left.
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_rem_sh  = {r_acc, r_q[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_b};
        if (w_div_op) begin
            if (!w_diff[WIDTH]) begin
                w_acc_next = w_diff[WIDTH-1:0];
                w_q_next   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = w_rem_sh[WIDTH-1:0];
                w_q_next   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_next = w_mul_sum[WIDTH:1];
            w_q_next   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
    end

    // High half of the negated double-width product: the low half only carries in when it is zero.
    assign w_mulh_neg = ~r_acc + {{(WIDTH-1){1'b0}}, (r_q == '0)};

    always_comb begin
        case (r_op)
            OP_MUL:   w_fix_result = r_q;
            OP_MULH:  w_fix_result = r_neg ? w_mulh_neg : r_acc;
            OP_MULHU: w_fix_result = r_acc;
            OP_DIV,
            OP_DIVU:  w_fix_result = r_div0 ? '1 : (r_neg ? -r_q : r_q);
            OP_REM:   w_fix_result = r_div0 ? r_a_orig : (r_neg ? -r_acc : r_acc);
            default:  w_fix_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_branch    <= 1'b1;
        end else begin
            if (w_accept && w_is_mc)
                r_cnt <= CNT_W'(WIDTH);
            else if (r_state == S_BUSY)
                r_cnt <= r_cnt - CNT_W'(1);

            if (flush)
                r_out_valid <= 1'b0;
            else if (w_load_sc || w_load_fix)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;

            if (w_load_sc) begin
                r_result <= w_sc_result;
                r_branch <= (w_sc_result == '0);
            end else if (w_load_fix) begin
                r_result <= w_fix_result;
                r_branch <= (w_fix_result == '0);
            end
        end
    end

    // Iteration datapath carries no reset; it is always reloaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_mc) begin
            r_op     <= alu_control;
            r_acc    <= '0;
            r_q      <= w_a_abs;
            r_b      <= w_b_abs;
            r_a_orig <= src_a;
            r_div0   <= (src_b == '0);
            r_neg    <= (alu_control == OP_REM) ? src_a[WIDTH-1]
                      : (w_signed_in && (src_a[WIDTH-1] ^ src_b[WIDTH-1]));
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign branch_alu = r_branch;

endmodule
